// File: rtl/irq_pending_5_pkg.sv
// Shared constants and the priority-encoder result type for the
// 5-source interrupt pending stage.
package irq_pending_5_pkg;
  localparam int          IRQ_NUM_SRC = 5;
  localparam int          IRQ_ID_W    = 3;
  localparam logic [2:0]  IRQ_ID_NONE = 3'd7;

  typedef struct packed {
    logic                valid;
    logic [IRQ_ID_W-1:0] id;
  } irq_sel_t;
endpackage

// File: rtl/irq_prio_enc_5.sv
// Combinational lowest-index-wins priority encoder over five request bits;
// reports IRQ_ID_NONE when nothing is set.
module irq_prio_enc_5
  import irq_pending_5_pkg::*;
(
  input  logic [IRQ_NUM_SRC-1:0] i_vec,
  output irq_sel_t               o_sel
);
  always_comb begin
    o_sel.valid = |i_vec;
    o_sel.id    = IRQ_ID_NONE;
    // Walk downward so the lowest set index is the last one written.
    for (int i = IRQ_NUM_SRC - 1; i >= 0; i--) begin
      if (i_vec[i]) o_sel.id = IRQ_ID_W'(i);
    end
  end
endmodule

// File: rtl/irq_pending_5.sv
// Event capture (edge/level, per-source polarity), pending hold with
// write-1-to-clear, enable masking and a registered highest-priority request.
module irq_pending_5
  import irq_pending_5_pkg::*;
#(
  parameter logic [IRQ_NUM_SRC-1:0] InvertMask = 5'b00000,
  parameter logic [IRQ_NUM_SRC-1:0] EdgeMask   = 5'b11111
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [IRQ_NUM_SRC-1:0] Event_In,
  input  logic                   Enable_We,
  input  logic [IRQ_NUM_SRC-1:0] Enable_Data,
  input  logic                   Clear_We,
  input  logic [IRQ_NUM_SRC-1:0] Clear_Data,
  output logic [IRQ_NUM_SRC-1:0] Raw_Pending,
  output logic [IRQ_NUM_SRC-1:0] Pending_Out,
  output logic                   Irq_Valid,
  output logic [IRQ_ID_W-1:0]    Irq_Id
);
  logic [IRQ_NUM_SRC-1:0] r_ev_q;
  logic [IRQ_NUM_SRC-1:0] r_pend;
  logic [IRQ_NUM_SRC-1:0] r_en;
  logic                   r_valid;
  logic [IRQ_ID_W-1:0]    r_id;

  logic [IRQ_NUM_SRC-1:0] w_ev;
  logic [IRQ_NUM_SRC-1:0] w_set;
  logic [IRQ_NUM_SRC-1:0] w_clr;
  logic [IRQ_NUM_SRC-1:0] w_pend_next;
  logic [IRQ_NUM_SRC-1:0] w_en_next;
  irq_sel_t               w_sel;

  assign w_ev        = Event_In ^ InvertMask;
  assign w_set       = (w_ev & ~r_ev_q & EdgeMask) | (w_ev & ~EdgeMask);
  assign w_clr       = Clear_We ? Clear_Data : '0;
  // Set is OR-ed after the clear so a same-cycle capture survives the clear.
  assign w_pend_next = (r_pend & ~w_clr) | w_set;
  assign w_en_next   = Enable_We ? Enable_Data : r_en;

  // Encoding the next-state keeps Irq_Valid/Irq_Id aligned with Pending_Out.
  irq_prio_enc_5 u_enc (
    .i_vec (w_pend_next & w_en_next),
    .o_sel (w_sel)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_ev_q  <= '1;
      r_pend  <= '0;
      r_en    <= '0;
      r_valid <= 1'b0;
      r_id    <= IRQ_ID_NONE;
    end else begin
      r_ev_q  <= w_ev;
      r_pend  <= w_pend_next;
      r_en    <= w_en_next;
      r_valid <= w_sel.valid;
      r_id    <= w_sel.id;
    end
  end

  assign Raw_Pending = r_pend;
  assign Pending_Out = r_pend & r_en;
  assign Irq_Valid   = r_valid;
  assign Irq_Id      = r_id;
endmodule

// File: tb/tb_irq_pending_5.sv
// Bench: three parameterisations share one stimulus stream and are checked
// every cycle against a per-source behavioural model, plus directed vectors.
module tb_irq_pending_5;
  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] Event_In = '0;
  logic       Enable_We = 1'b0;
  logic [4:0] Enable_Data = '0;
  logic       Clear_We = 1'b0;
  logic [4:0] Clear_Data = '0;

  logic [4:0] o_raw [3];
  logic [4:0] o_out [3];
  logic       o_v   [3];
  logic [2:0] o_id  [3];

  int total = 0;
  int bad   = 0;

  // Instance 0: defaults; 1: source 0 level; 2: source 0 active-low.
  localparam logic [2:0][4:0] INV = {5'b00001, 5'b00000, 5'b00000};
  localparam logic [2:0][4:0] EDG = {5'b11111, 5'b11110, 5'b11111};

  always #5 Clock = ~Clock;

  irq_pending_5 #(.InvertMask(5'b00000), .EdgeMask(5'b11111)) u_a (
    .Clock(Clock), .Reset(Reset), .Event_In(Event_In), .Enable_We(Enable_We),
    .Enable_Data(Enable_Data), .Clear_We(Clear_We), .Clear_Data(Clear_Data),
    .Raw_Pending(o_raw[0]), .Pending_Out(o_out[0]), .Irq_Valid(o_v[0]), .Irq_Id(o_id[0]));
  irq_pending_5 #(.InvertMask(5'b00000), .EdgeMask(5'b11110)) u_b (
    .Clock(Clock), .Reset(Reset), .Event_In(Event_In), .Enable_We(Enable_We),
    .Enable_Data(Enable_Data), .Clear_We(Clear_We), .Clear_Data(Clear_Data),
    .Raw_Pending(o_raw[1]), .Pending_Out(o_out[1]), .Irq_Valid(o_v[1]), .Irq_Id(o_id[1]));
  irq_pending_5 #(.InvertMask(5'b00001), .EdgeMask(5'b11111)) u_c (
    .Clock(Clock), .Reset(Reset), .Event_In(Event_In), .Enable_We(Enable_We),
    .Enable_Data(Enable_Data), .Clear_We(Clear_We), .Clear_Data(Clear_Data),
    .Raw_Pending(o_raw[2]), .Pending_Out(o_out[2]), .Irq_Valid(o_v[2]), .Irq_Id(o_id[2]));

  // Reference state: per-instance pending, enable, previous polarity-corrected input
  logic [4:0] m_pend [3];
  logic [4:0] m_en   [3];
  logic [4:0] m_prev [3];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [4:0] ev, input logic ew,
                       input logic [4:0] ed, input logic cw, input logic [4:0] cd);
    Reset = rst; Event_In = ev; Enable_We = ew; Enable_Data = ed;
    Clear_We = cw; Clear_Data = cd;
  endtask

  // Advance one clock: model computes its next state from the driven inputs,
  // then every instance is compared against it just after the edge.
  task automatic step();
    logic [4:0] np [3];
    logic [4:0] ne [3];
    logic [4:0] nv [3];
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        logic e, s;
        e = Event_In[i] ^ INV[k][i];
        s = EDG[k][i] ? (e && !m_prev[k][i]) : e;
        np[k][i] = (m_pend[k][i] && !(Clear_We && Clear_Data[i])) || s;
        nv[k][i] = e;
      end
      ne[k] = Enable_We ? Enable_Data : m_en[k];
      if (Reset) begin np[k] = '0; ne[k] = '0; nv[k] = 5'b11111; end
    end
    @(posedge Clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      logic [4:0] eo;
      logic [2:0] eid;
      m_pend[k] = np[k]; m_en[k] = ne[k]; m_prev[k] = nv[k];
      eo  = m_pend[k] & m_en[k];
      eid = 3'd7;
      for (int i = 4; i >= 0; i--) if (eo[i]) eid = 3'(i);
      chk($sformatf("model_raw[%0d]", k), {3'b0, o_raw[k]}, {3'b0, m_pend[k]});
      chk($sformatf("model_out[%0d]", k), {3'b0, o_out[k]}, {3'b0, eo});
      chk($sformatf("model_valid[%0d]", k), {7'b0, o_v[k]}, {7'b0, |eo});
      chk($sformatf("model_id[%0d]", k), {5'b0, o_id[k]}, {5'b0, eid});
    end
  endtask

  typedef struct {
    logic rst; logic [4:0] ev; logic ew; logic [4:0] ed; logic cw; logic [4:0] cd;
    logic [4:0] raw; logic [4:0] out; logic v; logic [2:0] id;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [4:0] ev, logic ew, logic [4:0] ed,
                              logic cw, logic [4:0] cd, logic [4:0] raw,
                              logic [4:0] out, logic v, logic [2:0] id);
    vec_t t;
    t.rst = rst; t.ev = ev; t.ew = ew; t.ed = ed; t.cw = cw; t.cd = cd;
    t.raw = raw; t.out = out; t.v = v; t.id = id;
    return t;
  endfunction

  vec_t tbl [18];

  initial begin
    for (int k = 0; k < 3; k++) begin m_pend[k] = '0; m_en[k] = '0; m_prev[k] = '0; end

    // Expected values are for the default instance (index 0).
    tbl[0]  = mk(1, 5'b00000, 0, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[1]  = mk(0, 5'b00000, 1, 5'b11111, 0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[2]  = mk(0, 5'b00100, 0, 5'b00000, 0, 5'b00000, 5'b00100, 5'b00100, 1, 3'd2);
    tbl[3]  = mk(0, 5'b00000, 0, 5'b00000, 0, 5'b00000, 5'b00100, 5'b00100, 1, 3'd2);
    tbl[4]  = mk(0, 5'b00000, 0, 5'b00000, 1, 5'b00100, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[5]  = mk(0, 5'b10010, 0, 5'b00000, 0, 5'b00000, 5'b10010, 5'b10010, 1, 3'd1);
    tbl[6]  = mk(0, 5'b00000, 0, 5'b00000, 1, 5'b00010, 5'b10000, 5'b10000, 1, 3'd4);
    tbl[7]  = mk(0, 5'b00000, 0, 5'b00000, 1, 5'b10000, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[8]  = mk(0, 5'b00000, 1, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[9]  = mk(0, 5'b01000, 0, 5'b00000, 0, 5'b00000, 5'b01000, 5'b00000, 0, 3'd7);
    tbl[10] = mk(0, 5'b00000, 1, 5'b01100, 0, 5'b00000, 5'b01000, 5'b01000, 1, 3'd3);
    tbl[11] = mk(0, 5'b00100, 0, 5'b00000, 1, 5'b00100, 5'b01100, 5'b01100, 1, 3'd2);
    tbl[12] = mk(0, 5'b00100, 0, 5'b00000, 1, 5'b00100, 5'b01000, 5'b01000, 1, 3'd3);
    tbl[13] = mk(0, 5'b00000, 1, 5'b11111, 1, 5'b01000, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[14] = mk(0, 5'b11111, 0, 5'b00000, 0, 5'b00000, 5'b11111, 5'b11111, 1, 3'd0);
    tbl[15] = mk(1, 5'b11111, 1, 5'b11111, 1, 5'b00000, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[16] = mk(0, 5'b11111, 0, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd7);
    tbl[17] = mk(0, 5'b00000, 1, 5'b11111, 0, 5'b00000, 5'b00000, 5'b00000, 0, 3'd7);

    for (int n = 0; n < 18; n++) begin
      drive(tbl[n].rst, tbl[n].ev, tbl[n].ew, tbl[n].ed, tbl[n].cw, tbl[n].cd);
      step();
      chk($sformatf("vec%0d_raw", n), {3'b0, o_raw[0]}, {3'b0, tbl[n].raw});
      chk($sformatf("vec%0d_out", n), {3'b0, o_out[0]}, {3'b0, tbl[n].out});
      chk($sformatf("vec%0d_valid", n), {7'b0, o_v[0]}, {7'b0, tbl[n].v});
      chk($sformatf("vec%0d_id", n), {5'b0, o_id[0]}, {5'b0, tbl[n].id});
    end

    // Level source 0 on instance 1 cannot be cleared while held high.
    drive(1, 5'b00000, 0, 5'b00000, 0, 5'b00000); step();
    drive(0, 5'b00000, 1, 5'b11111, 0, 5'b00000); step();
    for (int n = 0; n < 3; n++) begin
      drive(0, 5'b00001, 0, 5'b00000, 1, 5'b00001); step();
      chk("level_hold", {7'b0, o_raw[1][0]}, 8'd1);
    end
    drive(0, 5'b00000, 0, 5'b00000, 0, 5'b00000); step();
    chk("level_drop", {7'b0, o_raw[1][0]}, 8'd1);
    drive(0, 5'b00000, 0, 5'b00000, 1, 5'b00001); step();
    chk("level_clr", {7'b0, o_raw[1][0]}, 8'd0);

    // Active-low source 0 on instance 2: held active through reset, then a pulse.
    drive(1, 5'b00000, 0, 5'b00000, 0, 5'b00000); step();
    drive(0, 5'b00000, 1, 5'b11111, 0, 5'b00000); step();
    chk("inv_no_spur0", {3'b0, o_raw[2]}, 8'd0);
    drive(0, 5'b00000, 0, 5'b00000, 0, 5'b00000); step();
    chk("inv_no_spur1", {3'b0, o_raw[2]}, 8'd0);
    drive(0, 5'b00001, 0, 5'b00000, 0, 5'b00000); step();
    chk("inv_rise", {3'b0, o_raw[2]}, 8'd0);
    drive(0, 5'b00000, 0, 5'b00000, 0, 5'b00000); step();
    chk("inv_fall", {3'b0, o_raw[2]}, 8'h01);
    chk("inv_fall_id", {5'b0, o_id[2]}, 8'd0);
    drive(0, 5'b11110, 0, 5'b00000, 0, 5'b00000); step();
    chk("inv_all", {3'b0, o_raw[2]}, 8'h1f);
    drive(1, 5'b11110, 0, 5'b00000, 0, 5'b00000); step();
    chk("rst_raw", {3'b0, o_raw[2]}, 8'h00);
    chk("rst_out", {3'b0, o_out[2]}, 8'h00);
    chk("rst_valid", {7'b0, o_v[2]}, 8'd0);
    chk("rst_id", {5'b0, o_id[2]}, 8'd7);

    // Randomized traffic, all three instances checked against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) == 0), 5'($urandom),
            ($urandom_range(0, 3) == 0), 5'($urandom),
            ($urandom_range(0, 2) == 0), 5'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_pending_5.md
Name: irq_pending_5

Overview:
- Upstream interrupt/event capture stage for the MCU's 5-input OR interrupt combiner.
- Captures five external event sources (edge or level, per-source polarity), holds them as pending bits, and masks them with a software enable register.
- Presents the five masked pending lines to the OR stage.
- Also provides a registered request flag and the index of the highest-priority pending source for the core's trap logic.

Parameters:
- InvertMask, 5'b00000: bit i = 1 inverts Event_In[i] before detection (active-low source).
- EdgeMask, 5'b11111: bit i = 1 selects rising-edge capture for source i; 0 selects level capture.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- Event_In  in  5  raw event sources; already synchronous to Clock.
- Enable_We  in  1  write strobe for the enable register.
- Enable_Data  in  5  new enable mask; loaded when Enable_We = 1.
- Clear_We  in  1  write strobe for pending clear.
- Clear_Data  in  5  write-1-to-clear mask for pending bits.
- Raw_Pending  out  5  pending register, unmasked.
- Pending_Out  out  5  Raw_Pending & enable; feeds OR-stage inputs 1..5 (bit 0 = Input_1).
- Irq_Valid  out  1  registered OR of Pending_Out.
- Irq_Id  out  3  registered index of the lowest-numbered set bit of Pending_Out; 3'd7 when none.

Behaviour:
- Polarity: ev = Event_In ^ InvertMask. ev_q holds ev from the previous cycle.
- Set condition per bit i:
  - EdgeMask[i] = 1: set_i = ev[i] & ~ev_q[i].
  - EdgeMask[i] = 0: set_i = ev[i].
- Pending update each cycle: pend_next = (pend_q & ~(Clear_We ? Clear_Data : 0)) | set.
  - Set wins over clear in the same cycle and same bit.
  - Level sources therefore cannot be cleared while still asserted.
- Capture is independent of enable. A disabled source still latches pending and appears on Pending_Out as soon as it is enabled.
- Enable register: en_q <= Enable_Data when Enable_We = 1.
  - Simultaneous Enable_We and Clear_We both take effect in that same cycle.
- Pending_Out = pend_q & en_q. Combinational from registers; no extra latency.
- Irq_Valid and Irq_Id are registered from pend_next & en_next:
  - They update on the same edge as Raw_Pending/Pending_Out.
  - They are always consistent with Pending_Out in the same cycle.
- Latency:
  - Edge event sampled high at edge k (low at k-1) → Raw_Pending[i] = 1 after edge k.
  - If enabled, Pending_Out[i], Irq_Valid and Irq_Id are also valid after edge k.
- Priority: lowest index wins (source 0 highest). Irq_Id is in 0..4, or 7 when Irq_Valid = 0.
- Reset (synchronous, any cycle, including mid-burst):
  - pend_q = 0, en_q = 0.
  - Raw_Pending = 0, Pending_Out = 0, Irq_Valid = 0, Irq_Id = 3'd7.
  - ev_q = 5'b11111 (post-inversion), so a source already active when Reset deasserts does not produce a spurious edge capture. Level sources capture on the first cycle after reset.
- Reset has priority over all writes and events in the same cycle.
- No state other than ev_q, pend_q, en_q, Irq_Valid and Irq_Id.

Decomposition:
- Shared package: IRQ_NUM_SRC = 5, IRQ_ID_W = 3, IRQ_ID_NONE = 3'd7.
- One sub-module, irq_prio_enc_5:
  - Purely combinational: 5-bit vector → {valid, 3-bit lowest-set index, 7 if none}.
  - Instantiated once on pend_next & en_next.
  - Reusable by the trap unit.

Test Plan:
- Reset, then Enable 5'b11111, pulse Event_In[2] high 1 cycle (EdgeMask default) → Raw_Pending = 5'b00100, Pending_Out = 5'b00100, Irq_Valid = 1, Irq_Id = 2 after the pulse edge. Bit stays set after the pulse ends.
- Events on bits 4 and 1 simultaneously → Irq_Id = 1. Clear_Data = 5'b00010 → Irq_Id = 4 next cycle. Clear 5'b10000 → Irq_Valid = 0, Irq_Id = 7.
- Enable = 0, pulse Event_In[3] → Raw_Pending[3] = 1, Pending_Out = 0, Irq_Valid = 0. Then Enable_Data = 5'b01000 → Pending_Out = 5'b01000, Irq_Id = 3 after that edge.
- EdgeMask[0] = 0, hold Event_In[0] high, Clear 5'b00001 repeatedly → Raw_Pending[0] remains 1. Drop the input, then clear → 0.
- Same-cycle new edge on bit 2 and Clear 5'b00100 → bit 2 remains set (set wins).
- InvertMask = 5'b00001, Event_In[0] held low through Reset deassert → no capture. Later low→high→low on Event_In[0] → capture on the falling edge. Assert Reset with pending 5'b11111 → all outputs reset values next edge.
